// File: rtl/lms_pkg.sv
// Purpose : shared types and helpers for the LMS adaptive noise-cancelling core.
// Latency : n/a (package only: FSM state enum, saturation and accumulator-width functions).
// Backpr. : n/a.
package lms_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    OUTPUT = 2'd2,
    UPDATE = 2'd3
  } lms_state_e;

  // Width that holds NTAPS full-scale products without overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Clamp v to the signed range of a w-bit word; caller truncates to w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_sample_ring.sv
// Purpose : circular history of reference samples, read by tap offset (0 = newest).
// Latency : write lands on the clock edge; read is combinational from the stored ring.
// Backpr. : none; the caller only writes when it accepts a new sample.
// Ports   : clk_in/rst_in (sync, active-high), wr_en/wr_dat write newest sample,
//           rd_ofs selects x[n-rd_ofs], rd_dat returns it.
module lms_sample_ring #(
  parameter int NTAPS  = 64,
  parameter int DATA_W = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       wr_en,
  input  logic signed [DATA_W-1:0]   wr_dat,
  input  logic [$clog2(NTAPS)-1:0]   rd_ofs,
  output logic signed [DATA_W-1:0]   rd_dat
);
  localparam int TAP_W = $clog2(NTAPS);

  logic signed [DATA_W-1:0] mem [NTAPS];
  logic [TAP_W-1:0]         wr_ptr;
  logic [TAP_W-1:0]         rd_idx;

  // wr_ptr points one past the newest sample; modulo wrap comes from the pointer width.
  assign rd_idx = wr_ptr - TAP_W'(1) - rd_ofs;
  assign rd_dat = mem[rd_idx];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
      wr_ptr      <= wr_ptr + TAP_W'(1);
    end
  end

endmodule

// File: rtl/lms_anc_core.sv
// Purpose : LMS adaptive FIR for active noise cancellation, one MAC / one tap update per cycle.
// Latency : y_out/valid_out appear NTAPS+2 cycles after the accepted ready_in cycle.
// Backpr. : none; ready_in while busy is dropped and flagged on overrun_out.
// Ports   : clk_in, rst_in (sync, active-high); ready_in strobes ref_in/err_in/adapt_en_in;
//           y_out held between updates, valid_out pulses on update, busy_out = not IDLE.
// Config  : define LMS_LEAK_EN to add coefficient leakage (w -= w >>> LEAK_SHIFT) in UPDATE.
module lms_anc_core
  import lms_pkg::*;
#(
  parameter int NTAPS      = 64,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int COEF_FRAC  = 14,
  parameter int MU_SHIFT   = 8,
  parameter int LEAK_SHIFT = 12
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     ready_in,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic signed [DATA_W-1:0] err_in,
  input  logic                     adapt_en_in,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     valid_out,
  output logic                     busy_out,
  output logic                     overrun_out
);
  localparam int TAP_W     = $clog2(NTAPS);
  localparam int ACC_W     = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int UPD_SHIFT = MU_SHIFT + DATA_W - 1;
`ifdef LMS_LEAK_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif

  lms_state_e state_q, state_d;
  logic [TAP_W-1:0]          tap_q;
  logic                      last_tap;
  logic                      accept;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]  err_q;
  logic                      adapt_q;
  logic signed [COEF_W-1:0]  w [NTAPS];
  logic signed [COEF_W-1:0]  w_k;
  logic signed [DATA_W-1:0]  x_k;
  logic signed [PROD_W-1:0]  mac_prod;
  logic signed [2*DATA_W-1:0] upd_prod;
  logic signed [63:0]        leak_term;
  logic signed [63:0]        w_sum;
  logic signed [COEF_W-1:0]  w_new;

  // Only IDLE accepts; a strobe on the edge that returns to IDLE is still seen as busy.
  assign accept   = ready_in && (state_q == IDLE);
  assign last_tap = (tap_q == TAP_W'(NTAPS - 1));
  assign busy_out = (state_q != IDLE);

  lms_sample_ring #(
    .NTAPS  (NTAPS),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .wr_en  (accept),
    .wr_dat (ref_in),
    .rd_ofs (tap_q),
    .rd_dat (x_k)
  );

  // FILTER and UPDATE both walk tap_q, so one ring read port serves both passes.
  assign w_k       = w[tap_q];
  assign mac_prod  = PROD_W'(w_k) * PROD_W'(x_k);
  assign upd_prod  = (2*DATA_W)'(err_q) * (2*DATA_W)'(x_k);
  assign leak_term = LEAK_EN ? 64'(w_k >>> LEAK_SHIFT) : 64'sd0;
  // Arithmetic right shift floors toward minus infinity, which is the intended rounding.
  assign w_sum     = 64'(w_k) - leak_term + 64'(upd_prod >>> UPD_SHIFT);
  assign w_new     = COEF_W'(saturate(w_sum, COEF_W));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ready_in) state_d = FILTER;
      FILTER:  if (last_tap) state_d = OUTPUT;
      OUTPUT:  state_d = adapt_q ? UPDATE : IDLE;
      UPDATE:  if (last_tap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      err_q       <= '0;
      adapt_q     <= 1'b0;
      y_out       <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
      for (int i = 0; i < NTAPS; i++) w[i] <= '0;
    end else begin
      state_q     <= state_d;
      valid_out   <= 1'b0;
      overrun_out <= ready_in && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (ready_in) begin
            err_q   <= err_in;
            adapt_q <= adapt_en_in;
            acc_q   <= '0;
            tap_q   <= '0;
          end
        end
        FILTER: begin
          acc_q <= acc_q + ACC_W'(mac_prod);
          tap_q <= tap_q + TAP_W'(1);
        end
        OUTPUT: begin
          y_out     <= DATA_W'(saturate(64'(acc_q >>> COEF_FRAC), DATA_W));
          valid_out <= 1'b1;
          tap_q     <= '0;
        end
        UPDATE: begin
          w[tap_q] <= w_new;
          tap_q    <= tap_q + TAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_anc_core.sv
// Purpose : self-checking bench for lms_anc_core (NTAPS=8) against a sample-history model.
// Latency : n/a.
// Backpr. : n/a.
module tb_lms_anc_core;
  localparam int NT = 8;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int CF = 14;
  localparam int MU = 8;
  localparam int LS = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ready, adapt;
  logic signed [15:0] ref_s, err_s;
  logic signed [15:0] y;
  logic valid, busy, ovr;

  lms_anc_core #(
    .NTAPS(NT), .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF), .MU_SHIFT(MU), .LEAK_SHIFT(LS)
  ) dut (
    .clk_in(clk), .rst_in(rst), .ready_in(ready), .ref_in(ref_s), .err_in(err_s),
    .adapt_en_in(adapt), .y_out(y), .valid_out(valid), .busy_out(busy), .overrun_out(ovr)
  );

  int checks = 0;
  int errors = 0;

  // Model: mh[k] holds x[n-k] (shift-register view), mw[k] the coefficients.
  longint mw [NT];
  longint mh [NT];

  function automatic longint msat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      mw[k] = 0;
      mh[k] = 0;
    end
  endtask

  task automatic model_step(input longint r, input longint e, input bit a, output longint yo);
    longint acc, d, nw;
    for (int k = NT - 1; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = r;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += mw[k] * mh[k];
    yo = msat(acc >>> CF, DW);
    if (a) begin
      for (int k = 0; k < NT; k++) begin
        d  = (e * mh[k]) >>> (MU + DW - 1);
        nw = mw[k] + d;
`ifdef LMS_LEAK_EN
        nw = nw - (mw[k] >>> LS);
`endif
        mw[k] = msat(nw, CW);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; ref_s = '0; err_s = '0; adapt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Drives one sample from an IDLE, #1-after-edge start. inject>1 raises a stray strobe
  // with fresh random data in the cycle after edge 'inject'. Returns when idle again.
  task automatic send_sample(input logic signed [15:0] r, input logic signed [15:0] e,
                             input logic a, input int inject,
                             output logic signed [15:0] yg, output int lat,
                             output int vcnt, output int ocnt);
    ref_s = r; err_s = e; adapt = a; ready = 1'b1;
    lat = -1; vcnt = 0; ocnt = 0; yg = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1 || c == inject + 1) ready = 1'b0;
      if (c == inject) begin
        ready = 1'b1; ref_s = 16'($urandom); err_s = 16'($urandom);
      end
      if (valid) begin
        vcnt++;
        if (lat < 0) begin lat = c; yg = y; end
      end
      if (ovr) ocnt++;
      if (lat >= 0 && !busy) break;
    end
    ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (y !== 16'sd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (dut.w[k] !== 16'sd0) begin errors++; $display("FAIL reset_w%0d: got %0d expected 0", k, dut.w[k]); end
    end
  endtask

  task automatic test_zero_error();
    logic signed [15:0] yg; int lat, vc, oc; longint ym;
    do_reset();
    send_sample(16'sd1000, 16'sd0, 1'b1, -1, yg, lat, vc, oc);
    model_step(1000, 0, 1'b1, ym);
    checks++; if (lat !== NT + 2) begin errors++; $display("FAIL zero_err_latency: got %0d expected %0d", lat, NT + 2); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL zero_err_valid_width: got %0d expected 1", vc); end
    checks++; if (yg !== 16'sd0) begin errors++; $display("FAIL zero_err_y: got %0d expected 0", yg); end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (dut.w[k] !== 16'sd0) begin errors++; $display("FAIL zero_err_w%0d: got %0d expected 0", k, dut.w[k]); end
    end
  endtask

  task automatic test_single_tap();
    logic signed [15:0] yg; int lat, vc, oc; longint ym;
    do_reset();
    send_sample(16'sd16384, 16'sd16384, 1'b1, -1, yg, lat, vc, oc);
    model_step(16384, 16384, 1'b1, ym);
    checks++; if (dut.w[0] !== 16'sd32) begin errors++; $display("FAIL single_w0: got %0d expected 32", dut.w[0]); end
    for (int k = 1; k < NT; k++) begin
      checks++;
      if (dut.w[k] !== mw[k][15:0]) begin errors++; $display("FAIL single_w%0d: got %0d expected %0d", k, dut.w[k], mw[k]); end
    end
    send_sample(16'sd16384, 16'sd0, 1'b0, -1, yg, lat, vc, oc);
    model_step(16384, 0, 1'b0, ym);
    checks++; if (yg !== 16'sd32) begin errors++; $display("FAIL single_y: got %0d expected 32", yg); end
    checks++; if (yg !== ym[15:0]) begin errors++; $display("FAIL single_y_model: got %0d expected %0d", yg, ym); end
  endtask

  task automatic test_overrun();
    logic signed [15:0] yg, r, e; int lat, vc, oc; longint ym;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom); e = 16'($urandom);
      send_sample(r, e, 1'b1, -1, yg, lat, vc, oc);
      model_step(r, e, 1'b1, ym);
    end
    // Stray strobes: mid-FILTER, on the OUTPUT->IDLE edge, and on the UPDATE->IDLE edge.
    for (int s = 0; s < 3; s++) begin
      int inj;
      logic a;
      inj = (s == 0) ? 3 : ((s == 1) ? NT + 1 : 2 * NT + 1);
      a   = (s != 1);
      r = 16'($urandom); e = 16'($urandom);
      send_sample(r, e, a, inj, yg, lat, vc, oc);
      model_step(r, e, a, ym);
      checks++; if (oc !== 1) begin errors++; $display("FAIL overrun_pulses_%0d: got %0d expected 1", s, oc); end
      checks++; if (yg !== ym[15:0]) begin errors++; $display("FAIL overrun_y_%0d: got %0d expected %0d", s, yg, ym); end
      checks++; if (lat !== NT + 2) begin errors++; $display("FAIL overrun_latency_%0d: got %0d expected %0d", s, lat, NT + 2); end
      for (int k = 0; k < NT; k++) begin
        checks++;
        if (dut.w[k] !== mw[k][15:0]) begin errors++; $display("FAIL overrun_w%0d_%0d: got %0d expected %0d", k, s, dut.w[k], mw[k]); end
      end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_not_accepted_%0d: busy got %b expected 0", s, busy); end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] yg, r, e; logic a; int lat, vc, oc; longint ym;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      r = 16'($urandom); e = 16'($urandom); a = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin r = r >>> 3; e = e >>> 2; end
      send_sample(r, e, a, -1, yg, lat, vc, oc);
      model_step(r, e, a, ym);
      checks++; if (yg !== ym[15:0]) begin errors++; $display("FAIL rand_y_%0d: got %0d expected %0d", i, yg, ym); end
      checks++; if (oc !== 0) begin errors++; $display("FAIL rand_overrun_%0d: got %0d expected 0", i, oc); end
      for (int k = 0; k < NT; k++) begin
        checks++;
        if (dut.w[k] !== mw[k][15:0]) begin errors++; $display("FAIL rand_w%0d_%0d: got %0d expected %0d", k, i, dut.w[k], mw[k]); end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] yg; int lat, vc, oc, neg; longint ym;
    do_reset();
    neg = 0;
    for (int i = 0; i < 600; i++) begin
      send_sample(16'sd32767, 16'sd32767, 1'b1, -1, yg, lat, vc, oc);
      model_step(32767, 32767, 1'b1, ym);
      if (dut.w[0] < 0) neg++;
      checks++; if (yg !== ym[15:0]) begin errors++; $display("FAIL sat_y_%0d: got %0d expected %0d", i, yg, ym); end
    end
    checks++; if (neg !== 0) begin errors++; $display("FAIL sat_w0_negative: got %0d samples expected 0", neg); end
    checks++; if (dut.w[0] !== 16'sd32767) begin errors++; $display("FAIL sat_w0: got %0d expected 32767", dut.w[0]); end
    for (int k = 1; k < NT; k++) begin
      checks++;
      if (dut.w[k] !== mw[k][15:0]) begin errors++; $display("FAIL sat_w%0d: got %0d expected %0d", k, dut.w[k], mw[k]); end
    end
  endtask

  task automatic test_reset_mid_update();
    logic signed [15:0] yg, r, e; int lat, vc, oc, seen; longint ym;
    do_reset();
    send_sample(16'sd20000, 16'sd20000, 1'b1, -1, yg, lat, vc, oc);
    ref_s = 16'sd20000; err_s = 16'sd20000; adapt = 1'b1; ready = 1'b1;
    seen = 0;
    for (int c = 1; c <= 100 && seen == 0; c++) begin
      @(posedge clk); #1;
      ready = 1'b0;
      if (valid) seen = 1;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL midupd_valid_timeout: got %0d expected 1", seen); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midupd_busy: got %b expected 0", busy); end
    checks++; if (y !== 16'sd0) begin errors++; $display("FAIL midupd_y: got %0d expected 0", y); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midupd_valid: got %b expected 0", valid); end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (dut.w[k] !== 16'sd0) begin errors++; $display("FAIL midupd_w%0d: got %0d expected 0", k, dut.w[k]); end
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom); e = 16'($urandom);
      send_sample(r, e, 1'b1, -1, yg, lat, vc, oc);
      model_step(r, e, 1'b1, ym);
      checks++; if (yg !== ym[15:0]) begin errors++; $display("FAIL midupd_after_y_%0d: got %0d expected %0d", i, yg, ym); end
      checks++; if (lat !== NT + 2) begin errors++; $display("FAIL midupd_after_lat_%0d: got %0d expected %0d", i, lat, NT + 2); end
    end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (dut.w[k] !== mw[k][15:0]) begin errors++; $display("FAIL midupd_after_w%0d: got %0d expected %0d", k, dut.w[k], mw[k]); end
    end
  endtask

  task automatic test_leak();
    logic signed [15:0] yg, exp_w0; int lat, vc, oc; longint ym;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      send_sample(16'sd16384, 16'sd16384, 1'b1, -1, yg, lat, vc, oc);
      model_step(16384, 16384, 1'b1, ym);
    end
    checks++; if (dut.w[0] !== 16'sd4096) begin errors++; $display("FAIL leak_preload_w0: got %0d expected 4096", dut.w[0]); end
    send_sample(16'sd16384, 16'sd0, 1'b1, -1, yg, lat, vc, oc);
    model_step(16384, 0, 1'b1, ym);
`ifdef LMS_LEAK_EN
    exp_w0 = 16'sd4095;
`else
    exp_w0 = 16'sd4096;
`endif
    checks++; if (dut.w[0] !== exp_w0) begin errors++; $display("FAIL leak_w0: got %0d expected %0d", dut.w[0], exp_w0); end
    checks++; if (yg !== ym[15:0]) begin errors++; $display("FAIL leak_y: got %0d expected %0d", yg, ym); end
    for (int k = 1; k < NT; k++) begin
      checks++;
      if (dut.w[k] !== mw[k][15:0]) begin errors++; $display("FAIL leak_w%0d: got %0d expected %0d", k, dut.w[k], mw[k]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_error();
    test_single_tap();
    test_overrun();
    test_random();
    test_saturation();
    test_reset_mid_update();
    test_leak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
